// File: rtl/xor_cipher_pkg.sv
// Shared state encoding, default geometry and width helpers for the XOR stream cipher.
// Everything that depends on the key/lane/message geometry is derived here.
package xor_cipher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEY_LOAD,
        READY,
        STREAM,
        DONE
    } state_e;

    localparam int DEF_KEY_BITS     = 32;
    localparam int DEF_LANES        = 1;
    localparam int DEF_MAX_MSG_BITS = 512;

    function automatic int key_beats(input int key_bits, input int lanes);
        return key_bits / lanes;
    endfunction

    function automatic int msg_beats(input int max_msg_bits, input int lanes);
        return max_msg_bits / lanes;
    endfunction

    // The beat counter must be able to hold the beat limit itself.
    function automatic int beat_cnt_w(input int max_msg_bits, input int lanes);
        return $clog2(max_msg_bits / lanes) + 1;
    endfunction

    function automatic int key_cnt_w(input int key_bits, input int lanes);
        return $clog2(key_bits / lanes) + 1;
    endfunction

    function automatic int key_ptr_w(input int key_bits);
        return (key_bits > 1) ? $clog2(key_bits) : 1;
    endfunction

endpackage

// File: rtl/xor_stream_cipher_core_key_stream.sv
// Base/working key registers, bit pointer and LANES-wide keystream slice.
// On a stream start the slice is taken straight from the base key so the first beat needs no bubble.
module xor_key_stream
    import xor_cipher_pkg::*;
#(
    parameter int KEY_BITS = DEF_KEY_BITS,
    parameter int LANES    = DEF_LANES,
    parameter int ROLL_KEY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             shift_i,
    input  logic             clear_i,
    input  logic [LANES-1:0] shift_data_i,
    input  logic             start_i,
    input  logic             adv_i,
    output logic [LANES-1:0] slice_o
);

    localparam int            PW       = key_ptr_w(KEY_BITS);
    localparam logic [PW-1:0] PTR_LAST = PW'(KEY_BITS - LANES);
    localparam logic [PW-1:0] PTR_STEP = PW'(LANES);

    logic [KEY_BITS-1:0] base_q, base_d;
    logic [KEY_BITS-1:0] work_q, work_d;
    logic [KEY_BITS-1:0] src, shifted;
    logic [PW-1:0]       ptr_q, ptr_d, ptr_cur;
    logic                wrap;

    always_comb begin
        src     = start_i ? base_q : work_q;
        ptr_cur = start_i ? '0 : ptr_q;
        shifted = src << ptr_cur;
        slice_o = shifted[KEY_BITS-1 -: LANES];
        wrap    = (ptr_cur == PTR_LAST);

        base_d = base_q;
        work_d = work_q;
        ptr_d  = ptr_q;

        if (clear_i) begin
            base_d = '0;
        end else if (shift_i) begin
            base_d = (base_q << LANES) | KEY_BITS'(shift_data_i);
        end

        // Rotation applies to the working copy only; the base key stays as loaded.
        if (adv_i) begin
            ptr_d  = wrap ? '0 : ptr_cur + PTR_STEP;
            work_d = (wrap && ROLL_KEY != 0) ? {src[KEY_BITS-2:0], src[KEY_BITS-1]} : src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            work_q <= '0;
            ptr_q  <= '0;
        end else if (ena) begin
            base_q <= base_d;
            work_q <= work_d;
            ptr_q  <= ptr_d;
        end
    end

endmodule

// File: rtl/xor_stream_cipher_core.sv
// Streaming XOR cipher: serial key load, on-the-fly encryption, framed output.
// A beat waits one cycle in stage 1 so that a falling iLoad_msg can mark it as the last one.
module xor_stream_cipher_core
    import xor_cipher_pkg::*;
#(
    parameter int KEY_BITS     = DEF_KEY_BITS,
    parameter int LANES        = DEF_LANES,
    parameter int MAX_MSG_BITS = DEF_MAX_MSG_BITS,
    parameter int ROLL_KEY     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [LANES-1:0] iData_in,
    input  logic             iLoad_key,
    input  logic             iLoad_msg,
    output logic [LANES-1:0] oData_out,
    output logic             oValid,
    output logic             oStart,
    output logic             oEnd,
    output logic             oKey_ready,
    output logic             oOverflow
);

    localparam int KEY_BEATS = key_beats(KEY_BITS, LANES);
    localparam int MSG_BEATS = msg_beats(MAX_MSG_BITS, LANES);
    localparam int CW        = beat_cnt_w(MAX_MSG_BITS, LANES);
    localparam int KW        = key_cnt_w(KEY_BITS, LANES);

    if ((KEY_BITS % LANES) != 0 || (MAX_MSG_BITS % LANES) != 0) begin : g_bad_geometry
        $error("xor_stream_cipher_core: KEY_BITS and MAX_MSG_BITS must be multiples of LANES");
    end

    state_e            state_q, state_d;
    logic [KW-1:0]     key_cnt_q, key_cnt_d;
    logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
    logic              key_ready_q, key_ready_d;
    logic              overflow_q, overflow_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_first_q, s1_first_d;
    logic              s1_last_q, s1_last_d;
    logic [LANES-1:0]  s1_data_q, s1_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_start_q, out_start_d;
    logic              out_end_q, out_end_d;
    logic [LANES-1:0]  out_data_q, out_data_d;
    logic              ks_shift, ks_clear, ks_start, ks_adv;
    logic [LANES-1:0]  ks_slice;

    xor_key_stream #(
        .KEY_BITS (KEY_BITS),
        .LANES    (LANES),
        .ROLL_KEY (ROLL_KEY)
    ) u_key_stream (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .shift_i      (ks_shift),
        .clear_i      (ks_clear),
        .shift_data_i (iData_in),
        .start_i      (ks_start),
        .adv_i        (ks_adv),
        .slice_o      (ks_slice)
    );

    always_comb begin
        state_d     = state_q;
        key_cnt_d   = key_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        key_ready_d = key_ready_q;
        overflow_d  = overflow_q;
        ks_shift    = 1'b0;
        ks_clear    = 1'b0;
        ks_start    = 1'b0;
        ks_adv      = 1'b0;
        s1_valid_d  = 1'b0;
        s1_first_d  = 1'b0;
        s1_last_d   = 1'b0;
        s1_data_d   = s1_data_q;

        // Stage 2 resolves the end marker from the current iLoad_msg level.
        out_valid_d = s1_valid_q;
        out_data_d  = s1_valid_q ? s1_data_q : '0;
        out_start_d = s1_valid_q & s1_first_q;
        out_end_d   = s1_valid_q & (s1_last_q | ~iLoad_msg);

        case (state_q)
            IDLE, READY: begin
                if (iLoad_key) begin
                    ks_shift    = 1'b1;
                    key_ready_d = (KEY_BEATS == 1);
                    overflow_d  = 1'b0;
                    key_cnt_d   = KW'(1);
                    state_d     = (KEY_BEATS == 1) ? READY : KEY_LOAD;
                end else if (state_q == READY && iLoad_msg) begin
                    ks_start   = 1'b1;
                    ks_adv     = 1'b1;
                    s1_valid_d = 1'b1;
                    s1_first_d = 1'b1;
                    s1_last_d  = (MSG_BEATS == 1);
                    s1_data_d  = iData_in ^ ks_slice;
                    beat_cnt_d = CW'(1);
                    state_d    = (MSG_BEATS == 1) ? DONE : STREAM;
                end
            end
            KEY_LOAD: begin
                if (iLoad_key) begin
                    ks_shift  = 1'b1;
                    key_cnt_d = key_cnt_q + KW'(1);
                    if (key_cnt_q == KW'(KEY_BEATS - 1)) begin
                        key_ready_d = 1'b1;
                        state_d     = READY;
                    end
                end else begin
                    ks_clear  = 1'b1;
                    key_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            STREAM: begin
                if (iLoad_msg) begin
                    ks_adv     = 1'b1;
                    s1_valid_d = 1'b1;
                    s1_data_d  = iData_in ^ ks_slice;
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (beat_cnt_q == CW'(MSG_BEATS - 1)) begin
                        s1_last_d = 1'b1;
                        state_d   = DONE;
                    end
                end else begin
                    state_d = READY;
                end
            end
            DONE: begin
                if (iLoad_msg) begin
                    overflow_d = 1'b1;
                end else begin
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            key_ready_q <= 1'b0;
            overflow_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            out_end_q   <= 1'b0;
            out_data_q  <= '0;
        end else if (ena) begin
            state_q     <= state_d;
            key_cnt_q   <= key_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            key_ready_q <= key_ready_d;
            overflow_q  <= overflow_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_start_q <= out_start_d;
            out_end_q   <= out_end_d;
            out_data_q  <= out_data_d;
        end
    end

    assign oData_out  = out_data_q;
    assign oValid     = out_valid_q;
    assign oStart     = out_start_q;
    assign oEnd       = out_end_q;
    assign oKey_ready = key_ready_q;
    assign oOverflow  = overflow_q;

endmodule

// File: tb/tb_xor_stream_cipher_core.sv
// Bench for xor_stream_cipher_core: a 1-lane plain instance and a 4-lane rolling-key instance.
// Expected beats come from vector tables, constants or a bit-position keystream model.
module tb_xor_stream_cipher_core;

    typedef struct {
        logic [31:0] key;
        logic [63:0] msg;
        int          nbits;
        logic [63:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic       ena1 = 1'b1, lk1 = 1'b0, lm1 = 1'b0;
    logic [0:0] d1 = '0, o1_data;
    logic       o1_valid, o1_start, o1_end, o1_kr, o1_ov;

    logic       ena4 = 1'b1, lk4 = 1'b0, lm4 = 1'b0;
    logic [3:0] d4 = '0, o4_data;
    logic       o4_valid, o4_start, o4_end, o4_kr, o4_ov;

    logic [9:0] exp1_q[$];
    logic [9:0] exp4_q[$];
    logic [7:0] beats1[0:1023];
    logic [7:0] beats4[0:1023];
    int obs1_cnt = 0, obs4_cnt = 0;
    int start_cyc1 = -1, end_cyc1 = -1, drive_cyc1 = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xor_stream_cipher_core #(.KEY_BITS(32), .LANES(1), .MAX_MSG_BITS(512), .ROLL_KEY(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena1), .iData_in(d1), .iLoad_key(lk1), .iLoad_msg(lm1),
        .oData_out(o1_data), .oValid(o1_valid), .oStart(o1_start), .oEnd(o1_end),
        .oKey_ready(o1_kr), .oOverflow(o1_ov)
    );

    xor_stream_cipher_core #(.KEY_BITS(32), .LANES(4), .MAX_MSG_BITS(512), .ROLL_KEY(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena4), .iData_in(d4), .iLoad_key(lk4), .iLoad_msg(lm4),
        .oData_out(o4_data), .oValid(o4_valid), .oStart(o4_start), .oEnd(o4_end),
        .oKey_ready(o4_kr), .oOverflow(o4_ov)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, act, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Key bits for message beat idx: position in the repeating key plus one left rotation per completed pass.
    function automatic logic [7:0] model_beat(input logic [31:0] key, input int lanes, input bit roll,
                                              input int idx, input logic [7:0] din);
        int          bitpos = idx * lanes;
        int          r      = roll ? ((bitpos / 32) % 32) : 0;
        logic [31:0] k      = (key << r) | (key >> ((32 - r) % 32));
        logic [31:0] kw     = k << (bitpos % 32);
        return din ^ 8'(kw >> (32 - lanes));
    endfunction

    // Consumers take a beat at the next enabled edge, so a held output is counted once.
    always @(negedge clk) begin
        if (rst_n && ena1 && o1_valid) begin
            obs1_cnt++;
            if (o1_start) start_cyc1 = cyc;
            if (o1_end) end_cyc1 = cyc;
            if (exp1_q.size() == 0) fail("dut1_unexpected_beat", {o1_start, o1_end, 7'b0, o1_data});
            else check("dut1_beat{start,end,data}", {o1_start, o1_end, 7'b0, o1_data}, exp1_q.pop_front());
        end
        if (rst_n && ena4 && o4_valid) begin
            obs4_cnt++;
            if (exp4_q.size() == 0) fail("dut4_unexpected_beat", {o4_start, o4_end, 4'b0, o4_data});
            else check("dut4_beat{start,end,data}", {o4_start, o4_end, 4'b0, o4_data}, exp4_q.pop_front());
        end
    end

    task automatic load_key1(input logic [31:0] key);
        for (int i = 0; i < 32; i++) begin
            lk1 = 1'b1; d1 = key[31-i]; tick();
        end
        lk1 = 1'b0; d1 = '0;
    endtask

    task automatic load_key4(input logic [31:0] key);
        for (int i = 0; i < 8; i++) begin
            lk4 = 1'b1; d4 = key[31-4*i -: 4]; tick();
        end
        lk4 = 1'b0; d4 = '0;
    endtask

    task automatic send_msg1(input int n, input int stall_at, input int stall_len);
        for (int i = 0; i < n; i++) begin
            lm1 = 1'b1; d1 = beats1[i][0];
            if (i == 0) drive_cyc1 = cyc;
            if (i == stall_at) begin
                ena1 = 1'b0;
                repeat (stall_len) tick();
                ena1 = 1'b1;
            end
            tick();
        end
        lm1 = 1'b0; d1 = '0;
    endtask

    task automatic send_msg4(input int n);
        for (int i = 0; i < n; i++) begin
            lm4 = 1'b1; d4 = beats4[i][3:0]; tick();
        end
        lm4 = 1'b0; d4 = '0;
    endtask

    task automatic model_push1(input logic [31:0] key, input int n);
        int m = (n < 512) ? n : 512;
        for (int i = 0; i < m; i++)
            exp1_q.push_back({i == 0, i == m - 1, model_beat(key, 1, 1'b0, i, beats1[i])});
    endtask

    task automatic model_push4(input logic [31:0] key, input int n);
        for (int i = 0; i < n; i++)
            exp4_q.push_back({i == 0, i == n - 1, model_beat(key, 4, 1'b1, i, beats4[i])});
    endtask

    task automatic drain(input string name);
        int b = 0;
        while ((exp1_q.size() != 0 || exp4_q.size() != 0) && b < 50) begin
            tick(); b++;
        end
        tick(); tick();
        check({name, "_drain1"}, exp1_q.size(), 0);
        check({name, "_drain4"}, exp4_q.size(), 0);
    endtask

    task automatic check_out1_zero(input string name);
        check({name, "_valid"}, o1_valid, 0);
        check({name, "_start"}, o1_start, 0);
        check({name, "_end"}, o1_end, 0);
        check({name, "_data"}, o1_data, 0);
        check({name, "_key_ready"}, o1_kr, 0);
        check({name, "_overflow"}, o1_ov, 0);
    endtask

    initial begin
        logic [31:0] key;
        logic [63:0] w2;
        int n, obs_before;

        vecs[0] = '{32'hA5A50F0F, 64'h00000000_FFFFFFFF, 64, 64'hA5A50F0F_5A5AF0F0};
        vecs[1] = '{32'hFFFFFFFF, 64'h01234567_89ABCDEF, 64, 64'hFEDCBA98_76543210};
        vecs[2] = '{32'h00000000, 64'h00000000_DEADBEEF, 32, 64'h00000000_DEADBEEF};
        vecs[3] = '{32'h12345678, 64'h1, 1, 64'h1};
        vecs[4] = '{32'hF0F0F0F0, 64'h0000FFFF_0000FFFF, 48, 64'h00000F0F_F0F00F0F};
        vecs[5] = '{32'h80000001, 64'h0, 33, 64'h00000001_00000003};

        // Reset values
        #12;
        check_out1_zero("reset_dut1");
        check("reset_dut4_valid", o4_valid, 0);
        check("reset_dut4_data", o4_data, 0);
        check("reset_dut4_key_ready", o4_kr, 0);
        check("reset_dut4_overflow", o4_ov, 0);
        tick(); rst_n = 1'b1; tick();

        // Test 1 and vector table on the 1-lane instance
        for (int v = 0; v < 6; v++) begin
            load_key1(vecs[v].key);
            check("tbl_key_ready", o1_kr, 1);
            for (int i = 0; i < vecs[v].nbits; i++) begin
                beats1[i] = {7'b0, vecs[v].msg[vecs[v].nbits-1-i]};
                exp1_q.push_back({i == 0, i == vecs[v].nbits - 1, 7'b0, vecs[v].exp[vecs[v].nbits-1-i]});
            end
            start_cyc1 = -1; end_cyc1 = -1;
            send_msg1(vecs[v].nbits, -1, 0);
            drain("tbl");
            check("tbl_first_latency", start_cyc1 - drive_cyc1, 2);
            check("tbl_start_to_end", end_cyc1 - start_cyc1, vecs[v].nbits - 1);
            tick();
        end

        // Test 2: four lanes, rolling key, base key restored for the next message
        load_key4(32'h12345678);
        check("t2_key_ready", o4_kr, 1);
        w2 = 64'h12345678_2468ACF0;
        for (int i = 0; i < 16; i++) begin
            beats4[i] = 8'h0;
            exp4_q.push_back({i == 0, i == 15, 4'b0, w2[63-4*i -: 4]});
        end
        send_msg4(16);
        drain("t2a");
        w2 = 64'h12345678_00000000;
        for (int i = 0; i < 8; i++) exp4_q.push_back({i == 0, i == 7, 4'b0, w2[63-4*i -: 4]});
        send_msg4(8);
        drain("t2b");

        // Randomized messages against the keystream model
        for (int r = 0; r < 5; r++) begin
            key = $urandom;
            load_key1(key);
            n = $urandom_range(1, 150);
            for (int i = 0; i < n; i++) beats1[i] = 8'($urandom_range(0, 1));
            model_push1(key, n);
            send_msg1(n, -1, 0);
            key = $urandom;
            load_key4(key);
            n = $urandom_range(1, 100);
            for (int i = 0; i < n; i++) beats4[i] = 8'($urandom_range(0, 15));
            model_push4(key, n);
            send_msg4(n);
            drain("rand");
        end

        // Test 6: test-1 vector with a 3-cycle clock-enable stall, data held
        load_key1(vecs[0].key);
        for (int i = 0; i < 64; i++) begin
            beats1[i] = {7'b0, vecs[0].msg[63-i]};
            exp1_q.push_back({i == 0, i == 63, 7'b0, vecs[0].exp[63-i]});
        end
        start_cyc1 = -1; end_cyc1 = -1;
        send_msg1(64, 20, 3);
        drain("t6");
        check("t6_stretched_span", end_cyc1 - start_cyc1, 66);

        // Test 3: length limit, dropped beats, sticky overflow cleared by a key load
        key = $urandom;
        load_key1(key);
        for (int i = 0; i < 520; i++) beats1[i] = 8'($urandom_range(0, 1));
        model_push1(key, 520);
        obs_before = obs1_cnt;
        send_msg1(520, -1, 0);
        drain("t3");
        check("t3_beats_emitted", obs1_cnt - obs_before, 512);
        check("t3_overflow_set", o1_ov, 1);
        lk1 = 1'b1; d1 = key[31]; tick();
        check("t3_overflow_cleared", o1_ov, 0);
        check("t3_key_ready_cleared", o1_kr, 0);
        for (int i = 1; i < 32; i++) begin
            d1 = key[31-i]; tick();
        end
        lk1 = 1'b0; d1 = '0;
        check("t3_key_reloaded", o1_kr, 1);

        // Test 4: aborted key load, then a message that must be ignored
        for (int i = 0; i < 20; i++) begin
            lk1 = 1'b1; d1 = 1'($urandom_range(0, 1)); tick();
        end
        lk1 = 1'b0; d1 = '0; tick();
        check("t4_key_ready", o1_kr, 0);
        obs_before = obs1_cnt;
        for (int i = 0; i < 8; i++) beats1[i] = 8'($urandom_range(0, 1));
        send_msg1(8, -1, 0);
        repeat (4) tick();
        check("t4_no_output", obs1_cnt - obs_before, 0);

        // Test 5: asynchronous reset at message beat 100
        key = $urandom;
        load_key1(key);
        for (int i = 0; i < 200; i++) beats1[i] = 8'($urandom_range(0, 1));
        model_push1(key, 200);
        for (int i = 0; i < 200; i++) begin
            lm1 = 1'b1; d1 = beats1[i][0];
            if (i == 100) begin
                #1 rst_n = 1'b0;
                #1;
                check_out1_zero("t5_async_reset");
                break;
            end
            tick();
        end
        exp1_q.delete();
        lm1 = 1'b0; d1 = '0;
        tick(); tick(); rst_n = 1'b1; tick();
        obs_before = obs1_cnt;
        send_msg1(8, -1, 0);
        repeat (4) tick();
        check("t5_msg_ignored_after_reset", obs1_cnt - obs_before, 0);
        check("t5_key_ready_after_reset", o1_kr, 0);
        key = $urandom;
        load_key1(key);
        n = $urandom_range(10, 60);
        for (int i = 0; i < n; i++) beats1[i] = 8'($urandom_range(0, 1));
        model_push1(key, n);
        send_msg1(n, -1, 0);
        drain("t5_recovery");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout at cycle %0d, expected test completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
